// File: rtl/acc_bank.sv
// acc_bank: NUM_ACC flagged accumulators with load/add/sub/clear, bit-serial shifts
// and a registered output-enabled readback port.
module acc_bank #(
  parameter int WIDTH = 8,
  parameter int NUM_ACC = 4,
  parameter bit SAT_EN = 1'b0,
  localparam int SW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] Acc_in,
  input  logic [SW-1:0]    sel,
  input  logic [2:0]       op,
  input  logic [CW-1:0]    shamt,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             OE,
  output logic [WIDTH-1:0] Acc_out,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);
  localparam logic [2:0] OP_LOAD = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
                         OP_CLR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t r_state;
  logic [WIDTH-1:0] r_acc [NUM_ACC];
  logic [CW-1:0]    r_cnt;
  logic [SW-1:0]    r_tgt;
  logic             r_dir;
  logic             w_hit, w_aovf, w_sovf, w_out;
  logic [WIDTH-1:0] w_a, w_t, w_sat, w_add, w_sub, w_step;
  logic [WIDTH:0]   w_sum, w_dif;
  logic [CW-1:0]    w_amt;
  assign op_ready = (r_state == IDLE);
  assign w_hit  = 32'(sel) < NUM_ACC;
  assign w_a    = w_hit ? r_acc[sel] : '0;
  assign w_sum  = {1'b0, w_a} + {1'b0, Acc_in};
  assign w_dif  = {1'b0, w_a} - {1'b0, Acc_in};
  assign w_aovf = (w_a[WIDTH-1] == Acc_in[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
  assign w_sovf = (w_a[WIDTH-1] != Acc_in[WIDTH-1]) && (w_dif[WIDTH-1] != w_a[WIDTH-1]);
  // Overflow direction always follows the accumulator's sign for both ADD and SUB
  assign w_sat  = w_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_add  = (SAT_EN && w_aovf) ? w_sat : w_sum[WIDTH-1:0];
  assign w_sub  = (SAT_EN && w_sovf) ? w_sat : w_dif[WIDTH-1:0];
  assign w_amt  = (shamt > CW'(WIDTH)) ? CW'(WIDTH) : shamt;
  assign w_t    = r_acc[r_tgt];
  assign w_step = r_dir ? {1'b0, w_t[WIDTH-1:1]} : {w_t[WIDTH-2:0], 1'b0};
  assign w_out  = r_dir ? w_t[0] : w_t[WIDTH-1];
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
      Acc_out <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      if (OE) Acc_out <= w_a;
      if (r_state == SHIFT) begin
        r_acc[r_tgt] <= w_step;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_state <= IDLE;
          zero    <= (w_step == '0);
          carry   <= w_out;
          ovf     <= 1'b0;
        end
      end else if (op_valid && w_hit) begin
        case (op)
          OP_LOAD: begin
            r_acc[sel] <= Acc_in;
            zero <= (Acc_in == '0);
            carry <= 1'b0;
            ovf <= 1'b0;
          end
          OP_ADD: begin
            r_acc[sel] <= w_add;
            zero <= (w_add == '0);
            carry <= w_sum[WIDTH];
            ovf <= w_aovf;
          end
          OP_SUB: begin
            r_acc[sel] <= w_sub;
            zero <= (w_sub == '0);
            carry <= w_dif[WIDTH];
            ovf <= w_sovf;
          end
          OP_CLR: begin
            r_acc[sel] <= '0;
            zero <= 1'b1;
            carry <= 1'b0;
            ovf <= 1'b0;
          end
          OP_SHL, OP_SHR: begin
            if (w_amt == '0) begin
              zero <= (w_a == '0);
              carry <= 1'b0;
              ovf <= 1'b0;
            end else begin
              r_state <= SHIFT;
              r_cnt <= w_amt;
              r_tgt <= sel;
              r_dir <= (op == OP_SHR);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: scenario tasks with a readback scoreboard over plain, saturating and 3-entry banks.
module tb_acc_bank;
  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, ADD = 3'd2, SUB = 3'd3, SHL = 3'd5, SHR = 3'd6;
  logic CLK = 1'b0, RESET_N = 1'b0, op_valid = 1'b0, OE = 1'b0;
  logic [7:0] Acc_in = '0;
  logic [1:0] sel = '0;
  logic [2:0] op = '0;
  logic [3:0] shamt = '0;
  logic r0, r1, r2, z0, c0, v0, z1, c1, v1, z2, c2, v2;
  logic [7:0] o0, o1, o2;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  always #5 CLK = ~CLK;
  acc_bank #(.WIDTH(8), .NUM_ACC(4), .SAT_EN(1'b0)) u0 (.CLK(CLK), .RESET_N(RESET_N), .Acc_in(Acc_in),
    .sel(sel), .op(op), .shamt(shamt), .op_valid(op_valid), .op_ready(r0), .OE(OE), .Acc_out(o0),
    .zero(z0), .carry(c0), .ovf(v0));
  acc_bank #(.WIDTH(8), .NUM_ACC(4), .SAT_EN(1'b1)) u1 (.CLK(CLK), .RESET_N(RESET_N), .Acc_in(Acc_in),
    .sel(sel), .op(op), .shamt(shamt), .op_valid(op_valid), .op_ready(r1), .OE(OE), .Acc_out(o1),
    .zero(z1), .carry(c1), .ovf(v1));
  acc_bank #(.WIDTH(8), .NUM_ACC(3), .SAT_EN(1'b0)) u2 (.CLK(CLK), .RESET_N(RESET_N), .Acc_in(Acc_in),
    .sel(sel), .op(op), .shamt(shamt), .op_valid(op_valid), .op_ready(r2), .OE(OE), .Acc_out(o2),
    .zero(z2), .carry(c2), .ovf(v2));
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic doop(input logic [2:0] o, input logic [1:0] s, input logic [7:0] d, input logic [3:0] a);
    op = o; sel = s; Acc_in = d; shamt = a; op_valid = 1'b1;
    cyc();
    op_valid = 1'b0; op = NOP;
  endtask
  task automatic rd(input logic [1:0] s);
    op_valid = 1'b0; OE = 1'b1; sel = s;
    cyc();
    OE = 1'b0;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (r0 !== 1'b1 && n < 20) begin cyc(); n++; end
  endtask
  task automatic test_reset();
    logic [7:0] e;
    RESET_N = 1'b0; op_valid = 1'b1; op = LOAD; Acc_in = 8'hFF; OE = 1'b1; sel = 2'd0;
    cyc();
    checks++; if (o0 !== 8'h00 || o1 !== 8'h00) begin errors++; $display("FAIL reset_out got %h/%h exp 00", o0, o1); end
    checks++; if ({z0, c0, v0, r0} !== 4'b0001) begin errors++; $display("FAIL reset_flags got %b exp 0001", {z0, c0, v0, r0}); end
    RESET_N = 1'b1; op_valid = 1'b0; op = NOP; OE = 1'b0;
    q.push_back(8'h00);
    rd(2'd2);
    e = q.pop_front();
    checks++; if (o0 !== e) begin errors++; $display("FAIL reset_rd2 got %h exp %h", o0, e); end
  endtask
  task automatic test_overflow();
    logic [7:0] e;
    doop(LOAD, 2'd1, 8'h7F, 4'd0);
    doop(ADD, 2'd1, 8'h01, 4'd0);
    checks++; if ({z0, c0, v0} !== 3'b001) begin errors++; $display("FAIL add_ovf_flags got %b exp 001", {z0, c0, v0}); end
    checks++; if ({z1, c1, v1} !== 3'b001) begin errors++; $display("FAIL add_sat_flags got %b exp 001", {z1, c1, v1}); end
    q.push_back(8'h80); q.push_back(8'h7F);
    rd(2'd1);
    e = q.pop_front(); checks++; if (o0 !== e) begin errors++; $display("FAIL add_ovf_val got %h exp %h", o0, e); end
    e = q.pop_front(); checks++; if (o1 !== e) begin errors++; $display("FAIL add_sat_val got %h exp %h", o1, e); end
    doop(LOAD, 2'd1, 8'h80, 4'd0);
    doop(SUB, 2'd1, 8'h01, 4'd0);
    checks++; if ({z1, c1, v1} !== 3'b001) begin errors++; $display("FAIL sub_sat_flags got %b exp 001", {z1, c1, v1}); end
    q.push_back(8'h7F); q.push_back(8'h80);
    rd(2'd1);
    e = q.pop_front(); checks++; if (o0 !== e) begin errors++; $display("FAIL sub_ovf_val got %h exp %h", o0, e); end
    e = q.pop_front(); checks++; if (o1 !== e) begin errors++; $display("FAIL sub_sat_val got %h exp %h", o1, e); end
  endtask
  task automatic test_sub();
    logic [7:0] e;
    doop(LOAD, 2'd0, 8'h05, 4'd0);
    doop(SUB, 2'd0, 8'h05, 4'd0);
    checks++; if ({z0, c0, v0} !== 3'b100) begin errors++; $display("FAIL sub_zero_flags got %b exp 100", {z0, c0, v0}); end
    doop(SUB, 2'd0, 8'h01, 4'd0);
    checks++; if ({z0, c0, v0} !== 3'b010) begin errors++; $display("FAIL sub_borrow_flags got %b exp 010", {z0, c0, v0}); end
    q.push_back(8'hFF);
    rd(2'd0);
    e = q.pop_front(); checks++; if (o0 !== e) begin errors++; $display("FAIL sub_borrow_val got %h exp %h", o0, e); end
  endtask
  task automatic test_shift();
    logic [7:0] e;
    int n;
    doop(LOAD, 2'd2, 8'h81, 4'd0);
    op = SHL; sel = 2'd2; shamt = 4'd3; op_valid = 1'b1;
    cyc();
    op = LOAD; sel = 2'd3; Acc_in = 8'h55;
    wait_ready(n);
    checks++; if (n != 3) begin errors++; $display("FAIL shl_busy_cycles got %0d exp 3", n); end
    checks++; if ({z0, c0, v0} !== 3'b000) begin errors++; $display("FAIL shl_flags got %b exp 000", {z0, c0, v0}); end
    cyc();
    op_valid = 1'b0; op = NOP;
    q.push_back(8'h08); q.push_back(8'h55);
    rd(2'd2);
    e = q.pop_front(); checks++; if (o0 !== e) begin errors++; $display("FAIL shl_val got %h exp %h", o0, e); end
    rd(2'd3);
    e = q.pop_front(); checks++; if (o0 !== e) begin errors++; $display("FAIL held_load_val got %h exp %h", o0, e); end
    doop(LOAD, 2'd0, 8'hFF, 4'd0);
    doop(SHR, 2'd0, 8'h00, 4'd15);
    wait_ready(n);
    checks++; if (n != 8) begin errors++; $display("FAIL shr_clamp_cycles got %0d exp 8", n); end
    checks++; if ({z0, c0, v0} !== 3'b110) begin errors++; $display("FAIL shr_clamp_flags got %b exp 110", {z0, c0, v0}); end
    doop(SHL, 2'd0, 8'h00, 4'd0);
    checks++; if ({r0, z0, c0, v0} !== 4'b1100) begin errors++; $display("FAIL shamt0 got %b exp 1100", {r0, z0, c0, v0}); end
    q.push_back(8'h00);
    rd(2'd0);
    e = q.pop_front(); checks++; if (o0 !== e) begin errors++; $display("FAIL shr_clamp_val got %h exp %h", o0, e); end
  endtask
  task automatic test_reset_mid_shift();
    logic [7:0] e;
    doop(LOAD, 2'd3, 8'hF0, 4'd0);
    doop(LOAD, 2'd2, 8'hFF, 4'd0);
    doop(ADD, 2'd2, 8'h01, 4'd0);
    doop(SHR, 2'd3, 8'h00, 4'd4);
    cyc();
    checks++; if ({r0, z0, c0, v0} !== 4'b0110) begin errors++; $display("FAIL shift_hold_flags got %b exp 0110", {r0, z0, c0, v0}); end
    RESET_N = 1'b0;
    cyc();
    RESET_N = 1'b1;
    checks++; if ({r0, z0, c0, v0} !== 4'b1000) begin errors++; $display("FAIL midreset_state got %b exp 1000", {r0, z0, c0, v0}); end
    q.push_back(8'h00); q.push_back(8'h00);
    rd(2'd3);
    e = q.pop_front(); checks++; if (o0 !== e) begin errors++; $display("FAIL midreset_acc3 got %h exp %h", o0, e); end
    rd(2'd2);
    e = q.pop_front(); checks++; if (o0 !== e) begin errors++; $display("FAIL midreset_acc2 got %h exp %h", o0, e); end
  endtask
  task automatic test_oe();
    logic [7:0] e;
    int n;
    doop(LOAD, 2'd1, 8'h10, 4'd0);
    q.push_back(8'h10); q.push_back(8'h11);
    op = ADD; sel = 2'd1; Acc_in = 8'h01; op_valid = 1'b1; OE = 1'b1;
    cyc();
    op_valid = 1'b0; op = NOP; OE = 1'b0;
    e = q.pop_front(); checks++; if (o0 !== e) begin errors++; $display("FAIL oe_old_val got %h exp %h", o0, e); end
    rd(2'd1);
    e = q.pop_front(); checks++; if (o0 !== e) begin errors++; $display("FAIL oe_new_val got %h exp %h", o0, e); end
    doop(LOAD, 2'd0, 8'hA0, 4'd0);
    doop(LOAD, 2'd1, 8'hA1, 4'd0);
    doop(LOAD, 2'd2, 8'hA2, 4'd0);
    doop(LOAD, 2'd3, 8'hAA, 4'd0);
    doop(SHL, 2'd3, 8'h00, 4'd5);
    checks++; if (r2 !== 1'b1) begin errors++; $display("FAIL oor_shift_ready got %b exp 1", r2); end
    wait_ready(n);
    checks++; if (n != 5) begin errors++; $display("FAIL u0_shift5_cycles got %0d exp 5", n); end
    q.push_back(8'hA0); q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      e = q.pop_front(); checks++; if (o2 !== e) begin errors++; $display("FAIL oor_rd%0d got %h exp %h", i, o2, e); end
    end
  endtask
  task automatic test_model();
    logic [7:0] m[4];
    logic [7:0] a, b, e;
    logic [2:0] o;
    logic ec, ev;
    int s, t;
    for (int i = 0; i < 4; i++) begin
      m[i] = 8'($urandom);
      doop(LOAD, 2'(i), m[i], 4'd0);
    end
    for (int k = 0; k < 12; k++) begin
      t = int'($urandom_range(0, 3));
      b = 8'($urandom);
      o = ($urandom_range(0, 1) != 0) ? ADD : SUB;
      a = m[t];
      if (o == ADD) begin
        s = int'($signed(a)) + int'($signed(b)); e = a + b; ec = (int'(a) + int'(b)) > 255;
      end else begin
        s = int'($signed(a)) - int'($signed(b)); e = a - b; ec = a < b;
      end
      ev = (s > 127) || (s < -128);
      m[t] = e;
      q.push_back(e);
      doop(o, 2'(t), b, 4'd0);
      checks++; if ({z0, c0, v0} !== {e == 8'h00, ec, ev}) begin errors++; $display("FAIL model_flags%0d got %b exp %b", k, {z0, c0, v0}, {e == 8'h00, ec, ev}); end
      rd(2'(t));
      e = q.pop_front();
      checks++; if (o0 !== e) begin errors++; $display("FAIL model_val%0d got %h exp %h", k, o0, e); end
    end
  endtask
  initial begin
    test_reset();
    test_overflow();
    test_sub();
    test_shift();
    test_reset_mid_shift();
    test_oe();
    test_model();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc_bank.md
# acc_bank

Parametrised accumulator bank for the datapath: NUM_ACC accumulators of WIDTH bits each, replacing the single 8-bit accumulator. It supports load, add, subtract and clear, plus multi-cycle shifts through a valid/ready op handshake. Status flags are updated after every op, with optional saturation. A registered, output-enabled bus port reads back any accumulator.

## Interface
Parameters:
- WIDTH, 8, accumulator and bus width (≥2)
- NUM_ACC, 4, number of accumulators (≥1)
- SAT_EN, 0, 1 = ADD/SUB saturate to signed max/min on overflow

Ports (SW = max(1,$clog2(NUM_ACC)), CW = $clog2(WIDTH)+1):
- CLK, input, 1, single clock, all state updates on posedge
- RESET_N, input, 1, reset, synchronous, active-low
- Acc_in, input, WIDTH, operand / load data from bus
- sel, input, SW, accumulator index for op and for OE readback
- op, input, 3, 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 CLR, 101 SHL, 110 SHR (logical), 111 NOP
- shamt, input, CW, shift count for SHL/SHR (0..WIDTH)
- op_valid, input, 1, op request
- op_ready, output, 1, high when the bank can accept an op (state IDLE)
- OE, input, 1, capture acc[sel] into Acc_out
- Acc_out, output, WIDTH, registered bus output, holds value when OE low
- zero, carry, ovf, output, 1 each, flags of the last completed op

## Operation
- Op is accepted on an edge where op_valid & op_ready. Ops with op_valid high while op_ready is low are not accepted. The requester holds op_valid.
- LOAD: acc[sel] ← Acc_in; carry=0, ovf=0.
- ADD: acc[sel] ← acc + Acc_in; carry = unsigned carry-out; ovf = signed overflow.
- SUB: acc[sel] ← acc − Acc_in; carry = borrow (1 when acc < Acc_in unsigned); ovf = signed overflow.
- With SAT_EN=1 and ovf set, the ADD/SUB result is forced to 0111…1 (positive overflow) or 1000…0 (negative overflow). Flags are as above.
- CLR: acc[sel] ← 0; carry=0, ovf=0.
- SHL/SHR: multi-cycle, one bit per cycle. The target index is latched at acceptance, so later changes to sel do not redirect the shift. carry = last bit shifted out; ovf=0.
- Shift with shamt=0: completes in the accept cycle with no data change; carry=0, zero reflects acc.
- shamt > WIDTH is clamped to WIDTH; the result is 0.
- zero = (final result == 0) for every data op. NOP/reserved ops are accepted but change no accumulator and no flag.
- sel ≥ NUM_ACC: the op is accepted as NOP. OE with such a sel captures 0.
- OE is independent of ops. When OE is high, Acc_out ← acc[sel] as it was before this edge's update, i.e. the old value when an op targets the same accumulator in the same cycle.
- FSM: IDLE → SHIFT on acceptance of SHL/SHR with shamt≠0, loading cnt=shamt. In SHIFT, each edge shifts 1 bit and decrements cnt. The edge with cnt==1 writes the final bit, updates the flags and returns to IDLE.
- op_ready = (state==IDLE), combinational from state.

## Timing
- Reset (RESET_N low at a posedge): all acc=0, Acc_out=0, zero=carry=ovf=0, state=IDLE, cnt=0. op_ready=1 from the first edge after reset.
- Reset has priority over everything. Reset in mid-shift aborts the shift and clears all accumulators.
- LOAD/ADD/SUB/CLR: result and flags visible the edge after acceptance. Back-to-back acceptance every cycle is allowed. ADD reading an accumulator written the previous cycle uses the new value.
- Shift by k (1..WIDTH): op_ready low for exactly k cycles after the accept edge. The final value and flags are visible after edge k. The next op can be accepted on edge k+1.
- Intermediate shift values are visible to OE readback during SHIFT. Flags hold their previous values until completion.
- Acc_out updates only on edges with OE high; latency is 1 cycle.

## Test plan
- Reset: RESET_N low 1 cycle with all ops driven → Acc_out=0, flags 0, op_ready=1; OE sel=2 next cycle → Acc_out=0x00.
- Overflow, SAT_EN=0: LOAD acc1=0x7F, ADD 0x01 → acc1=0x80, ovf=1, carry=0, zero=0. SAT_EN=1, same stimulus → acc1=0x7F, ovf=1.
- SUB: acc0=0x05, SUB 0x05 → 0x00, zero=1, carry=0. Then SUB 0x01 → 0xFF, carry=1, ovf=0.
- SHL acc2=0x81, shamt=3, with op_valid held for a following LOAD: op_ready low 3 cycles, LOAD not accepted until edge 4. acc2=0x08, carry=0. Changing sel during the shift has no effect.
- Reset mid-shift: SHR acc3=0xF0, shamt=4, RESET_N low on the second SHIFT edge → acc3=0x00, flags 0, op_ready=1 next cycle.
- Same-cycle OE+ADD on sel=1 (acc1=0x10, Acc_in=0x01) → Acc_out=0x10, acc1=0x11. OE next cycle → Acc_out=0x11. sel=NUM_ACC with LOAD → accepted, no accumulator changed.
